// File: rtl/gate_sweep_if.sv
// Host/gate-facing signal bundle for the gate sweep controller.
// master = controller side; slave = test host plus gate under test.
interface gate_sweep_if #(
    parameter int N = 2
);
    logic                 start;
    logic [1:0]           op;
    logic                 gate_y;
    logic [N-1:0]         gate_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [(1<<N)-1:0]    captured;
    logic [N:0]           err_count;
    logic [N-1:0]         first_fail;
    logic                 fail_valid;

    modport master (
        input  start, op, gate_y,
        output gate_in, busy, done, pass, captured, err_count, first_fail, fail_valid
    );

    modport slave (
        output start, op, gate_y,
        input  gate_in, busy, done, pass, captured, err_count, first_fail, fail_valid
    );
endinterface

// File: rtl/gate_sweep_controller.sv
// Sweeps all 2^N vectors into a gate under test and checks each sample against a reference op.
// Each vector is held SETTLE+1 cycles; start is accepted only in IDLE and never queued.
module gate_sweep_controller #(
    parameter int N      = 2,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    gate_sweep_if.master bus
);
    localparam int NV = 1 << N;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [NV-1:0]   cap_q, cap_d;
    logic [N:0]      err_q, err_d;
    logic [N-1:0]    ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            pass_q, pass_d;
    logic            exp_y;
    logic            mismatch;

    function automatic logic ref_out(input logic [1:0] f, input logic [N-1:0] v);
        logic r;
        unique case (f)
            2'b00:   r = &v;
            2'b01:   r = |v;
            2'b10:   r = ^v;
            default: r = ~&v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            cap_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        cap_d    = cap_q;
        err_d    = err_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        pass_d   = pass_q;
        exp_y    = ref_out(op_q, vec_q);
        mismatch = (bus.gate_y != exp_y);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    vec_d   = '0;
                    cap_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                cap_d[vec_q] = bus.gate_y;
                if (mismatch) begin
                    err_d = err_q + (N+1)'(1);
                    if (!fv_q) begin
                        ff_d = vec_q;
                        fv_d = 1'b1;
                    end
                end
                // pass must reflect this final sample, hence err_d rather than err_q
                if (vec_q == VEC_LAST) begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N'(1);
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign bus.gate_in    = bus.busy ? vec_q : '0;
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = pass_q;
    assign bus.captured   = cap_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_valid = fv_q;
endmodule
